// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues reads to a synchronous instruction RAM,
// and presents instruction/PC pairs to IF/ID, with a skid buffer so stalls never drop a RAM response.
module fetch_stage #(
  parameter int          N        = 32,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         stall_i,
  input  logic         branch_taken_i,
  input  logic [N-1:0] branch_target_i,
  output logic [N-1:0] imem_addr_o,
  output logic         imem_rd_o,
  input  logic [N-1:0] imem_data_i,
  output logic [N-1:0] instruction_o,
  output logic [N-1:0] pc_o,
  output logic [N-1:0] pc_plus4_o,
  output logic         valid_o
);

  typedef enum logic [1:0] {
    ST_RESET,
    ST_RUN,
    ST_STALL
  } state_t;

  state_t state_q, state_d;

  logic [N-1:0] pc_q;
  logic [N-1:0] req_pc_q;
  logic         req_valid_q;
  logic [N-1:0] skid_instr;
  logic [N-1:0] skid_pc;
  logic         skid_valid;

  logic do_flush;
  logic do_stall;
  logic do_run;
  logic capture_skid;
  logic use_skid;

  // All PC arithmetic wraps modulo 2^N.
  function automatic logic [N-1:0] pc_inc(input logic [N-1:0] pc);
    return pc + N'(4);
  endfunction

  assign imem_addr_o = pc_q;
  assign imem_rd_o   = !RST && !stall_i && !branch_taken_i;
  assign pc_plus4_o  = pc_inc(pc_o);

  always_comb begin
    state_d  = state_q;
    do_flush = 1'b0;
    do_stall = 1'b0;
    do_run   = 1'b0;
    if (branch_taken_i) begin
      do_flush = 1'b1;
    end else if (stall_i) begin
      do_stall = 1'b1;
    end else begin
      do_run = 1'b1;
    end
    case (state_q)
      ST_RESET: state_d = ST_RUN;
      default:  state_d = do_stall ? ST_STALL : ST_RUN;
    endcase
  end

  // The skid only ever fills on a stall edge, so it is drained on the first run edge out of STALL.
  assign capture_skid = do_stall && req_valid_q && !skid_valid;
  assign use_skid     = skid_valid && (state_q == ST_STALL);

  // ---- control and output registers ----
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_RESET;
      pc_q          <= RESET_PC;
      req_valid_q   <= 1'b0;
      skid_valid    <= 1'b0;
      instruction_o <= '0;
      pc_o          <= '0;
      valid_o       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (do_flush) begin
        pc_q          <= branch_target_i;
        req_valid_q   <= 1'b0;
        skid_valid    <= 1'b0;
        valid_o       <= 1'b0;
        instruction_o <= '0;
      end else if (do_stall) begin
        req_valid_q <= 1'b0;
        if (capture_skid) begin
          skid_valid <= 1'b1;
        end
      end else if (do_run) begin
        if (use_skid) begin
          instruction_o <= skid_instr;
          pc_o          <= skid_pc;
          valid_o       <= 1'b1;
          skid_valid    <= 1'b0;
        end else begin
          instruction_o <= imem_data_i;
          pc_o          <= req_pc_q;
          valid_o       <= req_valid_q;
        end
        req_valid_q <= 1'b1;
        pc_q        <= pc_inc(pc_q);
      end
    end
  end

  // ---- request tag and skid payload (qualified by their valid bits) ----
  always_ff @(posedge CLK) begin
    if (do_run) begin
      req_pc_q <= pc_q;
    end
    if (capture_skid) begin
      skid_instr <= imem_data_i;
      skid_pc    <= req_pc_q;
    end
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage pipeline. Owns the PC, issues addresses to the synchronous-read instruction RAM, and presents fetched instruction/PC pairs with a valid bit to the IF/ID pipe register. Handles hazard-unit stalls without losing the in-flight RAM response, and branch redirects from EX without wrong-path issue.

## Interface
- N, 32, data/address width
- RESET_PC, 0, first fetch address after reset

- CLK  in  1  rising-edge clock
- RST  in  1  synchronous, active-high reset
- stall_i  in  1  hazard unit: hold outputs, issue no new fetch
- branch_taken_i  in  1  EX redirect request; priority over stall_i
- branch_target_i  in  N  redirect address
- imem_addr_o  out  N  RAM address, equals pc_q
- imem_rd_o  out  1  fetch issue strobe
- imem_data_i  in  N  RAM read data, valid one cycle after the issuing edge
- instruction_o  out  N  fetched instruction to IF/ID
- pc_o  out  N  address of instruction_o
- pc_plus4_o  out  N  pc_o + 4, combinational, mod 2^N
- valid_o  out  1  instruction_o/pc_o hold a real instruction

## Operation
- Internal state: pc_q (next address to issue), req_pc_q/req_valid_q (request issued last cycle, data on imem_data_i now), skid buffer skid_instr/skid_pc/skid_valid, output registers.
- imem_rd_o = !RST && !stall_i && !branch_taken_i; imem_addr_o = pc_q always.
- FSM states: RESET (RST high), RUN, STALL (stall_i high, no branch). RESET->RUN on RST low; RUN<->STALL on stall_i; any state -> RUN with redirect on branch_taken_i.
- Reset: pc_q=RESET_PC, req_valid_q=0, skid_valid=0, instruction_o=0, pc_o=0, valid_o=0.
- Branch (highest priority): pc_q<=branch_target_i; req_valid_q<=0; skid_valid<=0; valid_o<=0, instruction_o<=0 (NOP). Outputs flushed even during stall.
- Stall: pc_q, outputs held. req_valid_q<=0. If req_valid_q=1 and skid_valid=0, capture {imem_data_i, req_pc_q} into skid, skid_valid<=1.
- Run, skid_valid=1 (stall-release cycle): outputs<=skid, valid_o<=1, skid_valid<=0.
- Run, skid_valid=0: outputs<={imem_data_i, req_pc_q}, valid_o<=req_valid_q.
- Run, both cases: req_pc_q<=pc_q, req_valid_q<=1, pc_q<=pc_q+4.
- Arithmetic: all PC adds mod 2^N; 0xFFFFFFFC+4 wraps to 0. branch_target_i used unaligned as given.

## Timing
- Reset release: RESET_PC issued in first cycle with RST low (edge E0); data arrives E0..E1; valid_o=1, pc_o=RESET_PC after E1, i.e. 2 cycles.
- Steady state: one instruction per cycle, pc_o increments by 4.
- Redirect at edge Eb: valid_o=0 after Eb; target issued at Eb+1; valid_o=1 with pc_o=target after Eb+2 (2 bubbles).
- Stall: outputs frozen from first stall edge; release with in-flight capture gives zero bubbles (skid, then next sequential). Stall entered with req_valid_q=0 gives one bubble on release (valid_o=0).
- Stall and branch same cycle: branch wins.
- RST mid-stall or mid-redirect: all state to reset values next edge.

## Test plan
- RAM word at A = A ^ 0xA5A5_0000. Reset, run 6 cycles -> valid_o rises 2 cycles after RST low, pc_o 0,4,8,12, instruction_o 0xA5A5_0000, 0xA5A5_0004...
- Stall 3 cycles while pc_o=8 -> pc_o/instruction_o held at 8; imem_rd_o=0; after release pc_o 12 then 16, no gap, none skipped or duplicated.
- Branch to 0x40 while pc_o=12 -> valid_o=0 next 2 cycles, then pc_o=0x40, 0x44; addresses 16..20 never reach valid_o.
- Branch asserted together with stall_i -> flush wins; pc_o=target with valid_o=1 two cycles after stall_i drops (stall_i held low after branch).
- RESET_PC=0xFFFF_FFF8 -> pc_o 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; pc_plus4_o at 0xFFFF_FFFC equals 0.
- RST asserted during stall with skid full -> next cycle valid_o=0, pc_o=0; restart fetches RESET_PC, old skid data never appears.
